serial_alu: RTL and testbench
=============================

Name: serial_alu

Overview:
- Bit-serial WIDTH-bit ALU built around one instance of the existing singleALU 1-bit slice.
- Each cycle it steps the slice through one bit position, LSB first. It feeds the slice's a/b/carryIn/ALUControl inputs and consumes its Result/carryOut.
- Assembles the full-width result and NZCV flags for the datapath.
- Trades latency (WIDTH cycles) for area in the single-cycle-CPU lab datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- ALUControl  input  2  00 add, 01 sub (A+~B+1), 10 AND, 11 OR; captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse in DONE
- Result  output  WIDTH  final result; held until next accepted start
- ALUFlags  output  4  {N,Z,C,V}; held with Result

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, Result=0, ALUFlags=0.
  - Clears the internal bit index, carry register and operand registers.
  - Applies mid-RUN or in DONE; the partial result is discarded and no done pulse occurs.
- States IDLE, RUN, DONE:
  - IDLE→RUN on an edge with start=1. At that edge: latch a, b, ALUControl into opA/opB/ctl; idx=0; carry=ctl[0]; clear the shift register.
  - RUN: the slice sees a=opA[idx], b=opB[idx], carryIn=carry, ALUControl=ctl, all combinationally.
  - At each RUN edge: the slice Result is written into bit idx of the accumulator; carry←slice carryOut; idx←idx+1.
  - RUN→DONE at the edge that processes idx=WIDTH-1. At that same edge, Result and ALUFlags are updated from the complete accumulator.
  - DONE→IDLE unconditionally at the next edge.
- Latency:
  - Start accepted at edge E0; bits processed at edges E1..E_WIDTH.
  - done=1 for exactly the cycle following E_WIDTH.
  - Throughput: one operation per WIDTH+2 cycles.
- start handling:
  - Ignored while busy=1, including in DONE; no queueing.
  - Inputs a/b/ALUControl may change freely after acceptance without effect.
- Flags, computed on the final accumulator R:
  - N=R[WIDTH-1]; Z=(R==0).
  - C: the final slice carryOut for add/sub (sub: C=1 means no borrow); 0 for AND/OR.
  - V: for add/sub, V=(opA[W-1] ~^ (opB[W-1]^ctl[0])) & (opA[W-1]^R[W-1]); 0 for AND/OR.
- Carry register: updated every RUN cycle regardless of op. Its value is ignored for AND/OR.
- idx width is clog2(WIDTH). idx never wraps within RUN because the DONE transition precedes overflow.
- Result/ALUFlags:
  - Do not change during RUN; they reflect the previous operation until E_WIDTH.
  - No partial values are ever visible.

Test Plan (WIDTH=32):
- Add: reset 2 cycles; start with a=5, b=3, ctl=00 → done high exactly 33 edges after start edge; Result=0x00000008; ALUFlags=0000; busy high 33 cycles.
- Sub negative: a=3, b=5, ctl=01 → Result=0xFFFFFFFE; N=1,Z=0,C=0,V=0.
- Sub equal and overflow:
  - a=5, b=5, ctl=01 → Result=0; Z=1, C=1.
  - a=0x7FFFFFFF, b=1, ctl=00 → Result=0x80000000; N=1, V=1, C=0.
- Logic ops: a=0xF0F0F0F0, b=0xFF00FF00:
  - ctl=10 → 0xF000F000, C=V=0, N=1.
  - ctl=11 → 0xFFF0FFF0.
- Start while busy: start held high through a run with changing a/b → only the first operands are used; exactly one done pulse per WIDTH+2 cycles; second op starts only from IDLE.
- Reset mid-op: reset_n=0 at RUN cycle 10 → next cycle busy=0, done=0, Result=0, ALUFlags=0; no done pulse. A fresh start then completes normally with correct result.

Source files
------------

// File: rtl/serial_alu.sv
// Bit-serial ALU: steps one singleALU slice through WIDTH bit positions,
// LSB first, then publishes the assembled result together with NZCV flags.
module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [1:0]       ctl_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic             slice_res_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] acc_d;
  logic [3:0]       flags_d;

  // The single 1-bit slice; it only ever sees the currently selected bit.
  singleALU u_slice (
    .a          (op_a_q[idx_q]),
    .b          (op_b_q[idx_q]),
    .carryIn    (carry_q),
    .ALUControl (ctl_q),
    .Result     (slice_res_s),
    .carryOut   (slice_cout_s)
  );

  // Accumulator with the current slice bit merged in, and flags derived from it.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = slice_res_s;
    flags_d[3]   = acc_d[WIDTH-1];
    flags_d[2]   = (acc_d == {WIDTH{1'b0}});
    if (ctl_q[1] == 1'b0) begin
      // Arithmetic: carry out of the MSB slice and signed-overflow detection.
      flags_d[1] = slice_cout_s;
      flags_d[0] = (op_a_q[WIDTH-1] ~^ (op_b_q[WIDTH-1] ^ ctl_q[0]))
                 & (op_a_q[WIDTH-1] ^ acc_d[WIDTH-1]);
    end else begin
      flags_d[1] = 1'b0;
      flags_d[0] = 1'b0;
    end
  end

  // Sequencer: IDLE -> RUN (WIDTH bit steps) -> DONE -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_a_q   <= {WIDTH{1'b0}};
      op_b_q   <= {WIDTH{1'b0}};
      ctl_q    <= 2'b00;
      idx_q    <= {IW{1'b0}};
      carry_q  <= 1'b0;
      acc_q    <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      flags_q  <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= b;
            ctl_q   <= ALUControl;
            idx_q   <= {IW{1'b0}};
            // Subtract seeds the +1 of the two's complement through carry-in.
            carry_q <= ALUControl[0];
            acc_q   <= {WIDTH{1'b0}};
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= slice_cout_s;
          if (idx_q == LAST_IDX) begin
            // Last bit: publish the complete word; idx is not advanced past the top.
            result_q <= acc_d;
            flags_q  <= flags_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q <= idx_q + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          // start is deliberately ignored here; a new op is only taken from IDLE.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Result   = result_q;
  assign ALUFlags = flags_q;

endmodule

// 1-bit ALU slice: add/sub (b inverted for sub), AND, OR.
module singleALU (
  input  logic       a,
  input  logic       b,
  input  logic       carryIn,
  input  logic [1:0] ALUControl,
  output logic       Result,
  output logic       carryOut
);

  logic b_eff_s;

  // Full adder on the (optionally inverted) b operand plus the logic-op mux.
  always_comb begin
    b_eff_s  = b ^ ALUControl[0];
    carryOut = (a & b_eff_s) | (a & carryIn) | (b_eff_s & carryIn);
    case (ALUControl)
      2'b00:   Result = a ^ b_eff_s ^ carryIn;
      2'b01:   Result = a ^ b_eff_s ^ carryIn;
      2'b10:   Result = a & b;
      2'b11:   Result = a | b;
      default: Result = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu (WIDTH=32): latency, results, flags,
// start-while-busy handling and reset in the middle of an operation.
module tb_serial_alu;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   ALUControl;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic [3:0]   ALUFlags;

  int total;
  int bad;

  serial_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .ALUFlags   (ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, follow it for 33 edges, check timing, then result and flags.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [1:0] cv, input logic [W-1:0] exp_r, input logic [3:0] exp_f);
    int done_at;
    int done_cnt;
    int busy_cnt;
    logic [W-1:0] prev_r;
    prev_r     = Result;
    a          = av;
    b          = bv;
    ALUControl = cv;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    a        = ~av;
    b        = ~bv;
    done_at  = 0;
    done_cnt = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (i == 10) chk({tag, "_hold_during_run"}, Result, prev_r);
    end
    chk({tag, "_done_edge"}, done_at, 32);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, 33);
    chk({tag, "_result"}, Result, exp_r);
    chk({tag, "_flags"}, {28'd0, ALUFlags}, {28'd0, exp_f});
  endtask

  initial begin
    int done_cnt;
    int first_at;
    int second_at;
    logic [W-1:0] first_r;
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    ALUControl = 2'b00;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_flags", {28'd0, ALUFlags}, 32'd0);
    reset_n = 1'b1;
    tick();

    run_op("add_5_3",   32'd5,          32'd3,          2'b00, 32'h0000_0008, 4'b0000);
    run_op("sub_3_5",   32'd3,          32'd5,          2'b01, 32'hFFFF_FFFE, 4'b1000);
    run_op("sub_5_5",   32'd5,          32'd5,          2'b01, 32'h0000_0000, 4'b0110);
    run_op("add_ovf",   32'h7FFF_FFFF,  32'd1,          2'b00, 32'h8000_0000, 4'b1001);
    run_op("and_op",    32'hF0F0_F0F0,  32'hFF00_FF00,  2'b10, 32'hF000_F000, 4'b1000);
    run_op("or_op",     32'hF0F0_F0F0,  32'hFF00_FF00,  2'b11, 32'hFFF0_FFF0, 4'b1000);
    run_op("sub_big",   32'h8000_0000,  32'd1,          2'b01, 32'h7FFF_FFFF, 4'b0011);

    // start held high with operands changing every cycle after acceptance.
    a          = 32'd5;
    b          = 32'd3;
    ALUControl = 2'b00;
    start      = 1'b1;
    tick();
    done_cnt  = 0;
    first_at  = 0;
    second_at = 0;
    first_r   = 32'd0;
    for (int i = 1; i <= 70; i++) begin
      if (first_at == 0) begin
        a = 32'h1000_0000 + i;
        b = 32'h0300_0000 + i;
      end
      tick();
      if (done) begin
        done_cnt++;
        if (first_at == 0) begin
          first_at = i;
          first_r  = Result;
          a = 32'd100;
          b = 32'd23;
        end else begin
          second_at = i;
          start     = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("hold_first_edge", first_at, 32);
    chk("hold_first_result", first_r, 32'd8);
    chk("hold_second_edge", second_at, 66);
    chk("hold_done_count", done_cnt, 2);
    chk("hold_second_result", Result, 32'd123);
    tick();
    tick();

    // Reset at RUN cycle 10: everything clears and no done pulse follows.
    a          = 32'h1234_5678;
    b          = 32'd1;
    ALUControl = 2'b00;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", Result, 32'd0);
    chk("midrst_flags", {28'd0, ALUFlags}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("midrst_no_activity", done_cnt, 0);
    run_op("after_rst", 32'h1234_5678, 32'd1, 2'b00, 32'h1234_5679, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
